frag_depth_writer: RTL and testbench

Fragment depth-test and write-back stage, directly downstream of the rasterization/z queue. It pops 256-bit fragment records through a valid/ready handshake. Each fragment is bounds-checked and depth-tested against the z-buffer memory; passing fragments update both the z-buffer and the framebuffer. After reset, or on request, it first clears the z-buffer to far depth.

---
 rtl/frag_depth_writer_if.sv | 11 +
 rtl/frag_depth_writer.sv | 152 +++++++++++++++
 tb/tb_frag_depth_writer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frag_depth_writer_if.sv
// Fragment stream handshake between the z queue (master) and the depth
// writer (slave). One 256-bit record moves when frag_valid and frag_ready
// are both high on a rising clock edge.
interface frag_depth_writer_if;
    logic         frag_valid;
    logic         frag_ready;
    logic [255:0] frag_data;

    modport master (output frag_valid, output frag_data, input frag_ready);
    modport slave  (input frag_valid, input frag_data, output frag_ready);
endinterface

// File: rtl/frag_depth_writer.sv
// Fragment depth-test and write-back stage.
// Pops fragments from the z queue, tests them against the z-buffer and, on a
// pass, writes depth and colour to the same column-major address
// (x*HEIGHT + y). After reset, or on clear_req while idle, the whole z-buffer
// is swept to far depth (16'hFFFF) before any fragment is accepted.
//
// Build option: define FRAG_DEPTH_WRITER_FBCLEAR_EN to have the clear sweep
// also write black into the framebuffer.
//
// state  | meaning
// -------+--------------------------------------------------------------
// CLEAR  | sweeping idx over every pixel; one last cycle lets the final
//        | write drain while clearing is still high
// IDLE   | ready for a fragment or a clear request
// LOOKUP | z-buffer read address is on the port
// DECIDE | read data valid; bounds + depth test, issue writes on pass
module frag_depth_writer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frag_depth_writer_if.slave   frag,
    input  logic                 clear_req,
    output logic [ADDR_W-1:0]    zmem_raddr,
    input  logic [15:0]          zmem_rdata,
    output logic                 zmem_we,
    output logic [ADDR_W-1:0]    zmem_waddr,
    output logic [15:0]          zmem_wdata,
    output logic                 fb_we,
    output logic [ADDR_W-1:0]    fb_waddr,
    output logic [23:0]          fb_wdata,
    output logic                 clearing,
    output logic [15:0]          pass_count
);

    localparam logic [1:0] S_CLEAR  = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_LOOKUP = 2'd2;
    localparam logic [1:0] S_DECIDE = 2'd3;

    // idx is one bit wider than an address so it can hold the pixel count
    // itself, which marks the drain cycle after the last clear write.
    localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(WIDTH * HEIGHT);

    logic [1:0]        state;
    logic [ADDR_W:0]   idx;
    logic [15:0]       lat_x;
    logic [15:0]       lat_y;
    logic [15:0]       lat_z;
    logic [23:0]       lat_rgb;
    logic [ADDR_W-1:0] in_addr;
    logic              in_x;
    logic              in_y;
    logic              pass;
    logic              unused_bits;

    assign frag.frag_ready = (state == S_IDLE);

    // Only x, y, z and the top byte of each colour channel are meaningful.
    assign unused_bits = ^{frag.frag_data[207:56], frag.frag_data[47:40],
                           frag.frag_data[31:24], frag.frag_data[15:0]};

    // Incoming address and the depth-test verdict for the held fragment.
    always_comb begin
        in_addr = ADDR_W'(frag.frag_data[255:240]) * ADDR_W'(HEIGHT)
                + ADDR_W'(frag.frag_data[239:224]);
        // Sign bit clear first, then an unsigned compare is exact.
        in_x = ~lat_x[15] && (lat_x < 16'(WIDTH));
        in_y = ~lat_y[15] && (lat_y < 16'(HEIGHT));
        pass = in_x && in_y && ~lat_z[15] && (lat_z < zmem_rdata);
    end

    // Sequencer, registered write ports and the pass counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            idx        <= '0;
            clearing   <= 1'b1;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_z      <= '0;
            lat_rgb    <= '0;
            zmem_raddr <= '0;
            zmem_we    <= 1'b0;
            zmem_waddr <= '0;
            zmem_wdata <= '0;
            fb_we      <= 1'b0;
            fb_waddr   <= '0;
            fb_wdata   <= '0;
            pass_count <= '0;
        end else begin
            zmem_we <= 1'b0;
            fb_we   <= 1'b0;
            case (state)
                S_CLEAR: begin
                    if (idx == NPIX) begin
                        state    <= S_IDLE;
                        clearing <= 1'b0;
                    end else begin
                        zmem_we    <= 1'b1;
                        zmem_waddr <= idx[ADDR_W-1:0];
                        zmem_wdata <= 16'hFFFF;
`ifdef FRAG_DEPTH_WRITER_FBCLEAR_EN
                        fb_we      <= 1'b1;
                        fb_waddr   <= idx[ADDR_W-1:0];
                        fb_wdata   <= 24'h000000;
`endif
                        idx        <= idx + (ADDR_W+1)'(1);
                    end
                end
                S_IDLE: begin
                    if (clear_req) begin
                        state    <= S_CLEAR;
                        idx      <= '0;
                        clearing <= 1'b1;
                    end else if (frag.frag_valid) begin
                        lat_x      <= frag.frag_data[255:240];
                        lat_y      <= frag.frag_data[239:224];
                        lat_z      <= frag.frag_data[223:208];
                        lat_rgb    <= {frag.frag_data[55:48], frag.frag_data[39:32],
                                       frag.frag_data[23:16]};
                        // Registered here so the address sits on the port
                        // throughout LOOKUP and data returns for DECIDE.
                        zmem_raddr <= in_addr;
                        state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    state <= S_DECIDE;
                end
                S_DECIDE: begin
                    if (pass) begin
                        zmem_we    <= 1'b1;
                        zmem_waddr <= zmem_raddr;
                        zmem_wdata <= lat_z;
                        fb_we      <= 1'b1;
                        fb_waddr   <= zmem_raddr;
                        fb_wdata   <= lat_rgb;
                        pass_count <= pass_count + 16'd1;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frag_depth_writer.sv
// Scoreboard bench for frag_depth_writer on a 4x3 screen with a 1-cycle-read
// z-buffer model. Expected writes are queued when stimulus is issued and a
// separate monitor pops them as the DUT's write ports fire.
module tb_frag_depth_writer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_req = 1'b0;
    logic [AW-1:0] zmem_raddr;
    logic [15:0]   zmem_rdata;
    logic          zmem_we;
    logic [AW-1:0] zmem_waddr;
    logic [15:0]   zmem_wdata;
    logic          fb_we;
    logic [AW-1:0] fb_waddr;
    logic [23:0]   fb_wdata;
    logic          clearing;
    logic [15:0]   pass_count;

    logic [15:0]   zmem [16];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    wr_t  zq[$];
    wr_t  fbq[$];
    wr_t  mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [15:0] exp_pc = 16'd0;

    always #5 clk = ~clk;

    frag_depth_writer_if fif ();

    frag_depth_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frag       (fif.slave),
        .clear_req  (clear_req),
        .zmem_raddr (zmem_raddr),
        .zmem_rdata (zmem_rdata),
        .zmem_we    (zmem_we),
        .zmem_waddr (zmem_waddr),
        .zmem_wdata (zmem_wdata),
        .fb_we      (fb_we),
        .fb_waddr   (fb_waddr),
        .fb_wdata   (fb_wdata),
        .clearing   (clearing),
        .pass_count (pass_count)
    );

    // z-buffer: write commits at the edge, read data one cycle after address
    always @(posedge clk) begin
        if (zmem_we) zmem[zmem_waddr] <= zmem_wdata;
        zmem_rdata <= zmem[zmem_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic void exp_z(input int addr, input logic [15:0] d);
        wr_t w;
        w.addr = AW'(addr);
        w.data = {8'h00, d};
        zq.push_back(w);
    endfunction

    function automatic void exp_fb(input int addr, input logic [23:0] d);
        wr_t w;
        w.addr = AW'(addr);
        w.data = d;
        fbq.push_back(w);
    endfunction

    function automatic void push_clear();
        for (int i = 0; i < W*H; i++) begin
            exp_z(i, 16'hFFFF);
`ifdef FRAG_DEPTH_WRITER_FBCLEAR_EN
            exp_fb(i, 24'h000000);
`endif
        end
    endfunction

    function automatic logic [255:0] mk(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z, input logic [23:0] rgb);
        return {x, y, z, {19{8'hA5}}, rgb[23:16], 8'h3C, rgb[15:8], 8'hC3,
                rgb[7:0], 16'hDEAD};
    endfunction

    // Monitor: every write-port pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && zmem_we) begin
            if (zq.size() == 0) begin
                n_checks++;
                $display("FAIL zmem_write: actual addr %0h data %0h required no write",
                         zmem_waddr, zmem_wdata);
            end else begin
                mon_e = zq.pop_front();
                check("zmem_waddr", 32'(zmem_waddr), 32'(mon_e.addr));
                check("zmem_wdata", 32'(zmem_wdata), 32'(mon_e.data));
            end
        end
        if (rst_n && fb_we) begin
            if (fbq.size() == 0) begin
                n_checks++;
                $display("FAIL fb_write: actual addr %0h data %0h required no write",
                         fb_waddr, fb_wdata);
            end else begin
                mon_e = fbq.pop_front();
                check("fb_waddr", 32'(fb_waddr), 32'(mon_e.addr));
                check("fb_wdata", 32'(fb_wdata), 32'(mon_e.data));
            end
        end
    end

    // Called at a negedge; returns at the first negedge with frag_ready high.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!fif.frag_ready && n < 100) begin
            @(negedge clk);
            n++;
            check({name, "_ready_vs_clearing"}, 32'(fif.frag_ready & clearing), 32'd0);
        end
        check({name, "_ready_seen"}, 32'(fif.frag_ready), 32'd1);
    endtask

    // Present a fragment, queue its writes if it should pass, and check the
    // three-cycle occupancy and the counter afterwards.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic [23:0] rgb, input bit pass, input int addr,
                        input string name);
        fif.frag_data  = mk(x, y, z, rgb);
        fif.frag_valid = 1'b1;
        wait_ready(name);
        if (pass) begin
            exp_z(addr, z);
            exp_fb(addr, rgb);
            exp_pc = exp_pc + 16'd1;
        end
        @(negedge clk);
        fif.frag_valid = 1'b0;
        check({name, "_busy1"}, 32'(fif.frag_ready), 32'd0);
        @(negedge clk);
        check({name, "_busy2"}, 32'(fif.frag_ready), 32'd0);
        @(negedge clk);
        check({name, "_ready3"}, 32'(fif.frag_ready), 32'd1);
        check({name, "_pass_count"}, 32'(pass_count), 32'(exp_pc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fif.frag_valid = 1'b0;
        fif.frag_data  = '0;
        repeat (3) @(negedge clk);

        check("rst_clearing",   32'(clearing),       32'd1);
        check("rst_ready",      32'(fif.frag_ready), 32'd0);
        check("rst_zmem_we",    32'(zmem_we),        32'd0);
        check("rst_fb_we",      32'(fb_we),          32'd0);
        check("rst_pass_count", 32'(pass_count),     32'd0);
        check("rst_raddr",      32'(zmem_raddr),     32'd0);
        check("rst_waddr",      32'(zmem_waddr),     32'd0);
        check("rst_wdata",      32'(zmem_wdata),     32'd0);
        check("rst_fb_waddr",   32'(fb_waddr),       32'd0);
        check("rst_fb_wdata",   32'(fb_wdata),       32'd0);

        // Power-up clear with a fragment already waiting.
        push_clear();
        fif.frag_data  = mk(16'd2, 16'd1, 16'd100, 24'h123456);
        fif.frag_valid = 1'b1;
        rst_n = 1'b1;
        wait_ready("clear0");
        check("clear0_clearing_low", 32'(clearing),   32'd0);
        check("clear0_z_writes",     32'(zq.size()),  32'd0);
        check("clear0_fb_writes",    32'(fbq.size()), 32'd0);

        send(16'd2, 16'd1, 16'd100, 24'h123456, 1'b1, 7, "f_basic");

        // Back-to-back to the same pixel: hazard through the write port.
        send(16'd2, 16'd1, 16'd200, 24'h111111, 1'b0, 7, "f_deeper");
        send(16'd2, 16'd1, 16'd50,  24'h222222, 1'b1, 7, "f_closer");

        // Out-of-range and negative-depth fragments.
        send(16'hFFFF, 16'd0, 16'd10,   24'h333333, 1'b0, 0, "f_xneg");
        send(16'd4,    16'd0, 16'd10,   24'h444444, 1'b0, 0, "f_xhi");
        send(16'd0,    16'd3, 16'd10,   24'h555555, 1'b0, 0, "f_yhi");
        send(16'd1,    16'd1, 16'hFFFB, 24'h666666, 1'b0, 0, "f_zneg");

        // clear_req wins over a simultaneous fragment.
        fif.frag_data  = mk(16'd1, 16'd1, 16'd9, 24'h777777);
        fif.frag_valid = 1'b1;
        clear_req      = 1'b1;
        push_clear();
        @(negedge clk);
        clear_req      = 1'b0;
        fif.frag_valid = 1'b0;
        check("clrreq_ready",    32'(fif.frag_ready), 32'd0);
        check("clrreq_clearing", 32'(clearing),       32'd1);
        wait_ready("clear1");
        check("clear1_z_writes",  32'(zq.size()),  32'd0);
        check("clear1_fb_writes", 32'(fbq.size()), 32'd0);
        check("clear1_pass_count", 32'(pass_count), 32'(exp_pc));

        // Reset during DECIDE of a passing fragment.
        fif.frag_data  = mk(16'd3, 16'd2, 16'd7, 24'h888888);
        fif.frag_valid = 1'b1;
        wait_ready("rstmid");
        @(negedge clk);
        fif.frag_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_pass_count", 32'(pass_count), 32'd0);
        check("rstmid_clearing",   32'(clearing),   32'd1);
        check("rstmid_ready",      32'(fif.frag_ready), 32'd0);
        @(negedge clk);
        check("rstmid_zmem_we", 32'(zmem_we), 32'd0);
        check("rstmid_fb_we",   32'(fb_we),   32'd0);
        exp_pc = 16'd0;
        push_clear();
        rst_n = 1'b1;
        wait_ready("clear2");
        check("clear2_z_writes",  32'(zq.size()),  32'd0);
        check("clear2_fb_writes", 32'(fbq.size()), 32'd0);

        // Corner pixel, extreme depths, and equal depth rejected.
        send(16'd3, 16'd2, 16'd0,    24'h0000FF, 1'b1, 11, "f_corner");
        send(16'd0, 16'd0, 16'h7FFF, 24'hFF0000, 1'b1, 0,  "f_zmax");
        send(16'd0, 16'd0, 16'h7FFF, 24'h010101, 1'b0, 0,  "f_zequal");

        repeat (4) @(negedge clk);
        check("sb_z_drain",  32'(zq.size()),  32'd0);
        check("sb_fb_drain", 32'(fbq.size()), 32'd0);
        check("final_pass_count", 32'(pass_count), 32'(exp_pc));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
